// File: rtl/mux2x1_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mux2x1_arbiter_if
// Description : Bundles requester, output-buffer and counter signals of the
//               two-input arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface mux2x1_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_rdy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Environment side: producers and consumer.
    modport master (
        output req0, a0, req1, a1, y_rdy,
        input  gnt0, gnt1, s, y, y_valid, cnt0, cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0, a0, req1, a1, y_rdy,
        output gnt0, gnt1, s, y, y_valid, cnt0, cnt1
    );
endinterface
`default_nettype wire

// File: rtl/mux2x1_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mux2x1_arbiter
// Description : Two-requester arbiter feeding a one-entry output register via a
//               shared 2:1 mux. Define MUX_ARB_ROUND_ROBIN_EN for round-robin
//               tie-break; otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mux2x1_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         clrn,
    mux2x1_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_can_load;
    logic             w_any_req;
    logic             w_winner;
    logic             w_s;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_grant;
    logic [WIDTH-1:0] w_mux;

    assign w_can_load = (r_state == ST_EMPTY) || bus.y_rdy;
    assign w_any_req  = bus.req0 || bus.req1;

    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
            w_winner = ~r_last;
`else
            w_winner = 1'b0;
`endif
        end else if (bus.req1) begin
            w_winner = 1'b1;
        end
    end

    // Select parks on the last grantee when idle so the mux does not toggle.
    assign w_s     = w_any_req ? w_winner : r_last;
    assign w_gnt0  = w_can_load && !w_winner && bus.req0;
    assign w_gnt1  = w_can_load &&  w_winner && bus.req1;
    assign w_grant = w_gnt0 || w_gnt1;
    assign w_mux   = w_s ? bus.a1 : bus.a0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_grant && bus.y_rdy) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_y    <= '0;
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_y    <= w_mux;
            r_last <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && (r_cnt0 != C_CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_gnt1 && (r_cnt1 != C_CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.s       = w_s;
    assign bus.y       = r_y;
    assign bus.y_valid = (r_state == ST_FULL);
    assign bus.cnt0    = r_cnt0;
    assign bus.cnt1    = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_mux2x1_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mux2x1_arbiter
// Description : Vector-table bench for mux2x1_arbiter with an accepted-word
//               scoreboard; small counters make saturation quick to reach.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mux2x1_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       s;
    } vec_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    mux2x1_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux2x1_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[$];
    logic [7:0] sb[$];

    // Reference state, advanced from the expected grants in the vector table.
    logic       m_full;
    logic       m_last;
    logic [7:0] m_y;
    int         m_cnt0;
    int         m_cnt1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r0, input logic [7:0] a0, input logic r1,
                       input logic [7:0] a1, input logic rdy,
                       input logic g0, input logic g1, input logic s);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_y    = 8'h00;
        m_cnt0 = 0;
        m_cnt1 = 0;
        sb.delete();
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic cycle(input vec_t v);
        bus.req0  = v.r0;
        bus.a0    = v.a0;
        bus.req1  = v.r1;
        bus.a1    = v.a1;
        bus.y_rdy = v.rdy;
        @(negedge clk);
        chk("gnt0", 32'(bus.gnt0), 32'(v.g0));
        chk("gnt1", 32'(bus.gnt1), 32'(v.g1));
        chk("s", 32'(bus.s), 32'(v.s));
        chk("y_valid", 32'(bus.y_valid), 32'(m_full));
        chk("y", 32'(bus.y), 32'(m_y));
        chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        if (bus.y_valid && bus.y_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got word %0h expected none at %0t", bus.y, $time);
            end else begin
                chk("sb_word", 32'(bus.y), 32'(sb.pop_front()));
            end
        end
        if (v.g0) begin
            m_y = v.a0; m_full = 1'b1; m_last = 1'b0;
            if (m_cnt0 < 3) m_cnt0++;
            sb.push_back(v.a0);
        end else if (v.g1) begin
            m_y = v.a1; m_full = 1'b1; m_last = 1'b1;
            if (m_cnt1 < 3) m_cnt1++;
            sb.push_back(v.a1);
        end else if (v.rdy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //   r0  a0     r1  a1     rdy g0         g1         s
        add(1, 8'h5A, 0, 8'h00, 1, 1,         0,         0);         // first grant
        add(0, 8'h00, 0, 8'h00, 1, 0,         0,         0);         // drain, idle
        add(0, 8'h00, 1, 8'h33, 1, 0,         1,         1);         // last -> 1
        add(1, 8'h11, 1, 8'h22, 1, 1,         0,         0);         // tie x4
        add(1, 8'h11, 1, 8'h22, 1, RR?1'b0:1'b1, RR?1'b1:1'b0, RR?1'b1:1'b0);
        add(1, 8'h11, 1, 8'h22, 1, 1,         0,         0);
        add(1, 8'h11, 1, 8'h22, 1, RR?1'b0:1'b1, RR?1'b1:1'b0, RR?1'b1:1'b0);
        add(0, 8'h00, 1, 8'h44, 0, 0,         0,         1);         // backpressure x3
        add(0, 8'h00, 1, 8'h44, 0, 0,         0,         1);
        add(0, 8'h00, 1, 8'h44, 0, 0,         0,         1);
        add(0, 8'h00, 1, 8'h44, 1, 0,         1,         1);         // release
        add(0, 8'h00, 0, 8'h00, 1, 0,         0,         1);         // drain
        add(0, 8'h00, 0, 8'h00, 0, 0,         0,         1);         // empty idle
        add(1, 8'h66, 0, 8'h00, 1, 1,         0,         0);         // saturation
        add(1, 8'h77, 0, 8'h00, 1, 1,         0,         0);
        add(0, 8'h00, 0, 8'h00, 1, 0,         0,         0);
        add(1, 8'h88, 1, 8'h99, 0, RR?1'b0:1'b1, RR?1'b1:1'b0, RR?1'b1:1'b0); // empty loads w/o rdy
        add(1, 8'h88, 1, 8'h99, 0, 0,         0,         0);         // full stall
        add(0, 8'h00, 0, 8'h00, 1, 0,         0,         RR?1'b1:1'b0);

        bus.req0 = 1'b0; bus.a0 = '0; bus.req1 = 1'b0; bus.a1 = '0; bus.y_rdy = 1'b0;
        model_reset();

        #12;
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("rst_s", 32'(bus.s), 32'h1);
        chk("rst_gnt0", 32'(bus.gnt0), 32'h0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'h0);
        chk("rst_cnt0", 32'(bus.cnt0), 32'h0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'h0);
        #1 clrn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i]);
        end

        // Asynchronous reset between edges while a word is buffered.
        v = '{r0:1, a0:8'hAB, r1:0, a1:8'h00, rdy:0, g0:1, g1:0, s:0};
        cycle(v);
        chk("pre_rst_y_valid", 32'(bus.y_valid), 32'h1);
        bus.req0 = 1'b0;
        #2 clrn = 1'b0;
        #1;
        chk("arst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("arst_y", 32'(bus.y), 32'h0);
        chk("arst_s", 32'(bus.s), 32'h1);
        chk("arst_cnt0", 32'(bus.cnt0), 32'h0);
        chk("arst_gnt0", 32'(bus.gnt0), 32'h0);
        #3 clrn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        v = '{r0:1, a0:8'hC3, r1:0, a1:8'h00, rdy:1, g0:1, g1:0, s:0};
        cycle(v);
        v = '{r0:0, a0:8'h00, r1:0, a1:8'h00, rdy:1, g0:0, g1:0, s:0};
        cycle(v);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2x1_arbiter.md
# mux2x1_arbiter

Two-requester arbiter and output buffer that shares one 2:1 multiplexer datapath between two sources. It picks a winner, drives the mux select, captures the selected word into a one-entry output register, and holds that word until the downstream consumer accepts it. It sits in front of any consumer that takes one word per cycle from two producers.

## Interface

Parameters:
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 8: width of each per-requester grant counter.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `clrn`, input, 1: asynchronous active-low reset; takes effect immediately, independent of `clk`.
- `req0`, input, 1: requester 0 has a word to send; held until `gnt0`.
- `a0`, input, WIDTH: requester 0 data; stable while `req0` is high.
- `req1`, input, 1: requester 1 has a word to send; held until `gnt1`.
- `a1`, input, WIDTH: requester 1 data; stable while `req1` is high.
- `gnt0`, output, 1: combinational; `a0` is captured at this clock edge.
- `gnt1`, output, 1: combinational; `a1` is captured at this clock edge.
- `s`, output, 1: mux select; 0 selects `a0`, 1 selects `a1`.
- `y`, output, WIDTH: registered output word.
- `y_valid`, output, 1: `y` holds an unaccepted word.
- `y_rdy`, input, 1: consumer accepts `y` when `y_valid && y_rdy`.
- `cnt0`, output, CNT_W: saturating count of grants to requester 0.
- `cnt1`, output, CNT_W: saturating count of grants to requester 1.

## Operation

- `can_load` = `!y_valid || y_rdy`. The buffer is empty, or it is being drained in this cycle.
- Winner selection is combinational from `req0`, `req1` and the registered `last` (the index of the last grant):
  - Only one request: that requester wins.
  - Both request: winner = `!last` when round-robin is enabled (see Configuration).
  - No request: no winner, and `s` holds `last`.
- `s` = winner when a request exists, otherwise `last`.
- `gnt0` = `can_load && winner==0 && req0`, and likewise for `gnt1`. At most one grant is high in a cycle.
- On a clock edge where a grant is high:
  - `y` ← mux output
  - `y_valid` ← 1
  - `last` ← winner
  - that requester's counter increments, saturating at 2^CNT_W−1 and never wrapping.
- On an edge with `y_valid && y_rdy` and no grant: `y_valid` ← 0 and `y` holds its value.
- A simultaneous drain and grant gives a back-to-back replacement, with `y_valid` staying 1.
- Full buffer (`y_valid && !y_rdy`): no grants; requests stall and `y` is frozen.
- Internal state has two values: EMPTY (`y_valid`=0) and FULL (`y_valid`=1).
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on an accept with no grant.
  - FULL→FULL on an accept with a grant, or with no accept.

## Timing

- Reset values: `y`=0, `y_valid`=0, `last`=1 (so requester 0 wins the first tie), `cnt0`=`cnt1`=0.
- Resulting outputs during reset with no requests: `s`=1, `gnt0`=`gnt1`=0.
- Latency is 1 cycle: a request granted at edge N gives `y_valid`=1 after edge N.
- Throughput is one word per cycle while `y_rdy`=1.
- Reset asserted mid-transfer discards the buffered word. Requesters re-present their words after reset.
- `y_rdy` has a combinational path to `gnt0`/`gnt1`. There is no other combinational path from input to output, other than requests to `s` and grants.

## Configuration

- `MUX_ARB_ROUND_ROBIN_EN` defined: ties are resolved as `!last`, so the two requesters alternate.
- `MUX_ARB_ROUND_ROBIN_EN` undefined: fixed priority; requester 0 always wins a tie, and `last` is still tracked to drive `s` when idle.

## Test plan

- Reset with `clrn`=0 and `req0`=`req1`=0 → `y`=0, `y_valid`=0, `s`=1, counts 0. Then release, with `req0`=1, `a0`=8'h5A, `y_rdy`=1 → `gnt0` high in the same cycle; next cycle `y`=8'h5A, `y_valid`=1, `cnt0`=1.
- Both requesters held high with `a0`=8'h11, `a1`=8'h22, `y_rdy`=1 for 4 cycles:
  - Round-robin build → `y` sequence 11,22,11,22, `cnt0`=`cnt1`=2.
  - Build without the macro → `y` sequence 11,11,11,11, `gnt1` never high.
- Backpressure: `y_valid`=1 with `y_rdy`=0 for 3 cycles while `req1`=1 → `gnt1`=0 throughout and `y` unchanged. Raise `y_rdy` → `gnt1` high in the same cycle, and next cycle `y`=`a1` with `y_valid`=1.
- Drain with no request: `y_valid`=1, `y_rdy`=1, `req0`=`req1`=0 → next cycle `y_valid`=0, `y` held, `s`=`last`.
- Counter saturation with `CNT_W`=2: 5 grants to requester 0 → `cnt0` goes 1,2,3,3,3.
- Asynchronous reset pulse between clock edges while `y_valid`=1 → `y_valid`=0 and `y`=0 immediately, without waiting for a clock edge.
